// File: rtl/cda_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cda_pll_pkg
// Description : Shared types and constants for the PLL phase detector and
//               lock filter.
// Revision    : 1.0 - initial release
// ============================================================================
package cda_pll_pkg;

    localparam int c_LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REF_LEAD = 2'd1,
        ST_FB_LEAD  = 2'd2
    } pfd_state_t;

    // Largest magnitude a signed err_w-bit phase error can carry.
    function automatic int sat_max(input int err_w);
        return (1 << (err_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cda_lock_filter.sv
`default_nettype none
// ============================================================================
// Module      : cda_lock_filter
// Description : Consecutive good/bad comparison counters producing the PLL
//               locked flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cda_lock_filter
    import cda_pll_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_good,
    input  logic i_bad,
    output logic o_locked
);

    localparam logic [c_LOCK_CNT_W:0] c_GOOD_MAX = (c_LOCK_CNT_W+1)'(LOCK_COUNT);
    localparam logic [c_LOCK_CNT_W:0] c_BAD_MAX  = (c_LOCK_CNT_W+1)'(UNLOCK_COUNT);

    logic [c_LOCK_CNT_W-1:0] r_good;
    logic [c_LOCK_CNT_W-1:0] r_bad;
    logic                    r_locked;
    logic [c_LOCK_CNT_W:0]   w_good_inc;
    logic [c_LOCK_CNT_W:0]   w_bad_inc;

    assign w_good_inc = {1'b0, r_good} + (c_LOCK_CNT_W+1)'(1);
    assign w_bad_inc  = {1'b0, r_bad} + (c_LOCK_CNT_W+1)'(1);
    assign o_locked   = r_locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_good   <= '0;
            r_bad    <= '0;
            r_locked <= 1'b0;
        end else if (i_good) begin
            r_bad <= '0;
            if (w_good_inc >= c_GOOD_MAX) begin
                r_good   <= c_GOOD_MAX[c_LOCK_CNT_W-1:0];
                r_locked <= 1'b1;
            end else begin
                r_good <= w_good_inc[c_LOCK_CNT_W-1:0];
            end
        end else if (i_bad) begin
            r_good <= '0;
            // Bad streaks only matter once locked; otherwise keep the count clear.
            if (!r_locked) begin
                r_bad <= '0;
            end else if (w_bad_inc >= c_BAD_MAX) begin
                r_bad    <= '0;
                r_locked <= 1'b0;
            end else begin
                r_bad <= w_bad_inc[c_LOCK_CNT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cda_pfd_lock_det.sv
`default_nettype none
// ============================================================================
// Module      : cda_pfd_lock_det
// Description : Oversampled phase/frequency detector measuring ref/fb edge
//               error in clk cycles, with up/down, cycle-slip and lock outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cda_pfd_lock_det
    import cda_pll_pkg::*;
#(
    parameter int ERR_W        = 16,
    parameter int LOCK_WINDOW  = 2,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic                    up,
    output logic                    down,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    cycle_slip,
    output logic                    locked
);

    localparam int                 c_CNT_W   = ERR_W - 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(sat_max(ERR_W));
    localparam logic [ERR_W-1:0]   c_WINDOW  = ERR_W'(LOCK_WINDOW);

    logic                    r_ref_q;
    logic                    r_fb_q;
    logic                    w_ref_rise;
    logic                    w_fb_rise;
    pfd_state_t              r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_k;
    logic                    r_up;
    logic                    r_down;
    logic signed [ERR_W-1:0] r_phase_err;
    logic                    r_err_valid;
    logic                    r_cycle_slip;
    logic [ERR_W-1:0]        w_err_mag;
    logic                    w_good;
    logic                    w_bad;
    logic                    w_locked;

    // Edge history runs through reset so a level held across release is not an edge.
    always_ff @(posedge clk) begin
        r_ref_q <= ref_in;
        r_fb_q  <= fb_in;
    end

    assign w_ref_rise = ref_in & ~r_ref_q;
    assign w_fb_rise  = fb_in & ~r_fb_q;

    // Edge distance including the current cycle, saturating at the error range.
    assign w_k = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_phase_err  <= '0;
            r_err_valid  <= 1'b0;
            r_cycle_slip <= 1'b0;
        end else begin
            r_err_valid  <= 1'b0;
            r_cycle_slip <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ref_rise && w_fb_rise) begin
                        r_phase_err <= '0;
                        r_err_valid <= 1'b1;
                    end else if (w_ref_rise) begin
                        r_state <= ST_REF_LEAD;
                        r_up    <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_fb_rise) begin
                        r_state <= ST_FB_LEAD;
                        r_down  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_REF_LEAD: begin
                    if (w_fb_rise) begin
                        r_phase_err <= $signed({1'b0, w_k});
                        r_err_valid <= 1'b1;
                        r_cnt       <= '0;
                        if (!w_ref_rise) begin
                            r_state <= ST_IDLE;
                            r_up    <= 1'b0;
                        end
                    end else if (w_ref_rise) begin
                        r_cycle_slip <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= w_k;
                    end
                end
                ST_FB_LEAD: begin
                    if (w_ref_rise) begin
                        r_phase_err <= -$signed({1'b0, w_k});
                        r_err_valid <= 1'b1;
                        r_cnt       <= '0;
                        if (!w_fb_rise) begin
                            r_state <= ST_IDLE;
                            r_down  <= 1'b0;
                        end
                    end else if (w_fb_rise) begin
                        r_cycle_slip <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= w_k;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_up    <= 1'b0;
                    r_down  <= 1'b0;
                end
            endcase
        end
    end

    assign w_err_mag = r_phase_err[ERR_W-1] ? -r_phase_err : r_phase_err;
    assign w_good    = r_err_valid && (w_err_mag <= c_WINDOW);
    assign w_bad     = (r_err_valid && (w_err_mag > c_WINDOW)) || r_cycle_slip;

    cda_lock_filter #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_filter (
        .clk      (clk),
        .reset    (reset),
        .i_good   (w_good),
        .i_bad    (w_bad),
        .o_locked (w_locked)
    );

    assign up         = r_up;
    assign down       = r_down;
    assign phase_err  = r_phase_err;
    assign err_valid  = r_err_valid;
    assign cycle_slip = r_cycle_slip;
    assign locked     = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_cda_pfd_lock_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_cda_pfd_lock_det
// Description : Directed bench for cda_pfd_lock_det with a timestamp-based
//               reference model; a 4-bit error instance covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cda_pfd_lock_det;

    localparam int LW = 2;
    localparam int LC = 4;
    localparam int UC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ref_in = 1'b0;
    logic fb_in = 1'b0;

    logic               up, down, err_valid, cycle_slip, locked;
    logic signed [15:0] phase_err;
    logic               s_up, s_down, s_err_valid, s_cycle_slip, s_locked;
    logic signed [3:0]  s_phase_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model state: which side leads (+1 ref, -1 fb, 0 none) and when it rose.
    int m_t = 0, m_lead = 0, m_t_lead = 0;
    int m_prev_ref = 0, m_prev_fb = 0;
    int m_good = 0, m_bad = 0;
    int e_up = 0, e_down = 0, e_err = 0, e_ev = 0, e_slip = 0, e_locked = 0;

    always #5 clk = ~clk;

    cda_pfd_lock_det #(.ERR_W(16), .LOCK_WINDOW(LW), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut (
        .clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in),
        .up(up), .down(down), .phase_err(phase_err), .err_valid(err_valid),
        .cycle_slip(cycle_slip), .locked(locked));

    cda_pfd_lock_det #(.ERR_W(4), .LOCK_WINDOW(LW), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut_s (
        .clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in),
        .up(s_up), .down(s_down), .phase_err(s_phase_err), .err_valid(s_err_valid),
        .cycle_slip(s_cycle_slip), .locked(s_locked));

    function automatic int clamp(input int v, input int m);
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one sampling edge with the inputs that edge saw.
    task automatic model_step(input int r, input int f, input int rst);
        int rr, fr, lead_e, close_e, mag;
        m_t++;
        rr = r & ~m_prev_ref;
        fr = f & ~m_prev_fb;
        m_prev_ref = r;
        m_prev_fb  = f;
        if (rst != 0) begin
            m_lead = 0; m_good = 0; m_bad = 0;
            e_up = 0; e_down = 0; e_err = 0; e_ev = 0; e_slip = 0; e_locked = 0;
            return;
        end
        mag = (e_err < 0) ? -e_err : e_err;
        if (e_ev != 0 && mag <= LW) begin
            m_bad = 0;
            m_good = (m_good + 1 > LC) ? LC : m_good + 1;
            if (m_good == LC) e_locked = 1;
        end else if (e_ev != 0 || e_slip != 0) begin
            m_good = 0;
            if (e_locked != 0) begin
                m_bad++;
                if (m_bad >= UC) begin e_locked = 0; m_bad = 0; end
            end else begin
                m_bad = 0;
            end
        end
        e_ev = 0;
        e_slip = 0;
        if (m_lead == 0) begin
            if (rr != 0 && fr != 0) begin e_err = 0; e_ev = 1; end
            else if (rr != 0) begin m_lead = 1; m_t_lead = m_t; end
            else if (fr != 0) begin m_lead = -1; m_t_lead = m_t; end
        end else begin
            lead_e  = (m_lead == 1) ? rr : fr;
            close_e = (m_lead == 1) ? fr : rr;
            if (close_e != 0) begin
                e_err = m_lead * clamp(m_t - m_t_lead, 32767);
                e_ev = 1;
                if (lead_e != 0) m_t_lead = m_t;
                else m_lead = 0;
            end else if (lead_e != 0) begin
                e_slip = 1;
                m_t_lead = m_t;
            end
        end
        e_up   = (m_lead == 1) ? 1 : 0;
        e_down = (m_lead == -1) ? 1 : 0;
    endtask

    task automatic cyc(input logic r, input logic f);
        ref_in = r;
        fb_in  = f;
        @(posedge clk);
        #1;
        model_step(int'(r), int'(f), int'(reset));
    endtask

    // One measurement window: each input pulses high for 5 cycles at its offset (-1 = none).
    task automatic period(input int dr, input int df, input int len);
        for (int i = 0; i < len; i++)
            cyc((dr >= 0 && i >= dr && i < dr + 5), (df >= 0 && i >= df && i < df + 5));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("up", {31'd0, up}, e_up);
            chk("down", {31'd0, down}, e_down);
            chk("phase_err", 32'(phase_err), e_err);
            chk("err_valid", {31'd0, err_valid}, e_ev);
            chk("cycle_slip", {31'd0, cycle_slip}, e_slip);
            chk("locked", {31'd0, locked}, e_locked);
            chk("s.up", {31'd0, s_up}, e_up);
            chk("s.down", {31'd0, s_down}, e_down);
            chk("s.phase_err", 32'(s_phase_err), clamp(e_err, 7));
            chk("s.err_valid", {31'd0, s_err_valid}, e_ev);
            chk("s.cycle_slip", {31'd0, s_cycle_slip}, e_slip);
            chk("s.locked", {31'd0, s_locked}, e_locked);
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_phase_err", 32'(phase_err), 0);
        chk("rst_locked", {31'd0, locked}, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);

        // ref leads fb by 3 cycles while unlocked
        for (int i = 0; i < 20; i++) begin
            cyc((i < 5), (i >= 3 && i < 8));
            if (i == 0) chk("lead3_up_on", {31'd0, up}, 1);
            if (i == 2) chk("lead3_up_hold", {31'd0, up}, 1);
            if (i == 3) begin
                chk("lead3_up_off", {31'd0, up}, 0);
                chk("lead3_err", 32'(phase_err), 3);
                chk("lead3_ev", {31'd0, err_valid}, 1);
                chk("model_lead3", e_err, 3);
            end
        end
        chk("lead3_locked", {31'd0, locked}, 0);

        // aligned edges: lock after the fourth zero-error comparison
        for (int p = 0; p < 5; p++) begin
            period(0, 0, 20);
            if (p == 2) chk("aligned3_locked", {31'd0, locked}, 0);
            if (p == 3) chk("aligned4_locked", {31'd0, locked}, 1);
        end
        chk("aligned_err", 32'(phase_err), 0);
        chk("model_locked", e_locked, 1);

        // fb leads by 2: good comparison, stays locked
        period(2, 0, 20);
        chk("fblead2_err", 32'(phase_err), -2);
        chk("fblead2_locked", {31'd0, locked}, 1);

        // two ref edges without fb, then a late fb close
        for (int i = 0; i < 30; i++) begin
            cyc((i < 5) || (i >= 10 && i < 15), (i >= 15 && i < 20));
            if (i == 10) begin
                chk("slip_pulse", {31'd0, cycle_slip}, 1);
                chk("slip_no_ev", {31'd0, err_valid}, 0);
            end
            if (i == 12) chk("slip_still_locked", {31'd0, locked}, 1);
        end
        chk("slip_close_err", 32'(phase_err), 5);
        chk("slip_unlocked", {31'd0, locked}, 0);

        // fb withheld 20 cycles: 4-bit instance saturates at +7
        period(0, 20, 30);
        chk("sat_err16", 32'(phase_err), 20);
        chk("sat_err4", 32'(s_phase_err), 7);

        // ref held high across reset release is not an edge
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("held_ref_no_up", {31'd0, up}, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        // reset during REF_LEAD aborts the measurement
        cyc(1'b1, 1'b0);
        chk("abort_up_on", {31'd0, up}, 1);
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b1);
        chk("abort_up_off", {31'd0, up}, 0);
        chk("abort_no_ev", {31'd0, err_valid}, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("post_abort_err", 32'(phase_err), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
